// File: rtl/axis_iter_divider.sv
// axis_iter_divider: iterative 32-bit radix-2 restoring divider behind AXI-Stream.
// Collects a divisor and a dividend (in any order), runs 32 restoring steps,
// then presents {quotient, remainder} until the consumer takes it.
module axis_iter_divider #(
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid,
  input  logic        m_axis_dout_tready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic        haveDividend_q;
  logic        haveDivisor_q;
  logic        dividendSign_q;
  logic        divisorSign_q;
  logic [31:0] divisorMag_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  cnt_q;
  logic [63:0] doutData_q;
  logic        doutValid_q;

  logic        dividendFire;
  logic        divisorFire;
  logic        dividendSign_d;
  logic        divisorSign_d;
  logic [31:0] dividendMag_d;
  logic [31:0] divisorMag_d;
  logic [32:0] trial;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] quoOut;
  logic [31:0] remOut;

  // A channel is open only while collecting and while its operand slot is still empty
  assign s_axis_dividend_tready = (state_q == IDLE) && !haveDividend_q;
  assign s_axis_divisor_tready  = (state_q == IDLE) && !haveDivisor_q;
  assign m_axis_dout_tdata      = doutData_q;
  assign m_axis_dout_tvalid     = doutValid_q;

  // Operand magnitudes/signs, one restoring step, and the sign-corrected final result
  always_comb begin
    dividendFire   = s_axis_dividend_tvalid && s_axis_dividend_tready;
    divisorFire    = s_axis_divisor_tvalid && s_axis_divisor_tready;
    dividendSign_d = SIGNED && s_axis_dividend_tdata[31];
    divisorSign_d  = SIGNED && s_axis_divisor_tdata[31];
    dividendMag_d  = dividendSign_d ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
    divisorMag_d   = divisorSign_d ? (32'd0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;
    trial          = {rem_q, quo_q[31]} - {1'b0, divisorMag_q};
    rem_d          = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    quo_d          = {quo_q[30:0], ~trial[32]};
    quoOut         = (dividendSign_q ^ divisorSign_q) ? (32'd0 - quo_d) : quo_d;
    remOut         = dividendSign_q ? (32'd0 - rem_d) : rem_d;
  end

  // Control FSM and datapath registers; reset discards any division in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      haveDividend_q <= 1'b0;
      haveDivisor_q  <= 1'b0;
      dividendSign_q <= 1'b0;
      divisorSign_q  <= 1'b0;
      divisorMag_q   <= 32'd0;
      rem_q          <= 32'd0;
      quo_q          <= 32'd0;
      cnt_q          <= 5'd0;
      doutData_q     <= 64'd0;
      doutValid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The dividend magnitude goes straight into the quotient shift register
          if (dividendFire) begin
            quo_q          <= dividendMag_d;
            dividendSign_q <= dividendSign_d;
            haveDividend_q <= 1'b1;
          end
          if (divisorFire) begin
            divisorMag_q  <= divisorMag_d;
            divisorSign_q <= divisorSign_d;
            haveDivisor_q <= 1'b1;
          end
          if ((haveDividend_q || dividendFire) && (haveDivisor_q || divisorFire)) begin
            state_q <= CALC;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q     <= DONE;
            doutData_q  <= {quoOut, remOut};
            doutValid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result data is left in place after the handshake
          if (m_axis_dout_tready) begin
            doutValid_q    <= 1'b0;
            haveDividend_q <= 1'b0;
            haveDivisor_q  <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_iter_divider.md
# axis_iter_divider

Iterative 32-bit radix-2 restoring divider that sits behind an AXI-Stream slave interface: two operand channels (divisor, dividend) and one result channel. It is the in-house replacement for the vendor divider cores that the execute-stage divider wrapper instantiates. The wrapper uses one instance with `SIGNED=1` and one with `SIGNED=0`. The result packs `{quotient, remainder}`, which the wrapper swaps into HI/LO.

## Interface

Parameters:
- `SIGNED`, default 0. 1 = two's-complement division; 0 = unsigned division.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_axis_divisor_tdata` in 32: divisor operand.
- `s_axis_divisor_tvalid` in 1: divisor valid.
- `s_axis_divisor_tready` out 1: divisor accepted when `tvalid && tready`.
- `s_axis_dividend_tdata` in 32: dividend operand.
- `s_axis_dividend_tvalid` in 1: dividend valid.
- `s_axis_dividend_tready` out 1: dividend accepted when `tvalid && tready`.
- `m_axis_dout_tdata` out 64: `[63:32]` quotient, `[31:0]` remainder.
- `m_axis_dout_tvalid` out 1: result valid; held until the handshake completes.
- `m_axis_dout_tready` in 1: result consumer ready. Tie it to 1 if there is no backpressure.

## Operation

States:
- **IDLE**: collect operands. Per channel, a `have_*` flag marks an operand already captured.
  - `s_axis_*_tready = (state==IDLE) && !have_*`, derived combinationally from registered state.
  - On a channel handshake, capture the operand magnitude (`|x|` if `SIGNED`, else `x`) and its sign bit (0 if `!SIGNED`), and set `have_*`.
  - Operands may arrive in the same cycle or in separate cycles, in either order. A captured operand is held; that channel's tready stays low until the result handshake.
  - When both operands are present (including the edge that captures the second one), go to CALC with `cnt=0`, partial remainder `R=0`, and `Q=|dividend|`.
- **CALC**: one restoring step per cycle.
  - `T = {R[31:0], Q[31]} - {1'b0, |divisor|}` (33-bit).
  - If `T[32]==0`: `R <= T[31:0]`, `Q <= {Q[30:0],1}`. Otherwise `R <= {R[30:0],Q[31]}`, `Q <= {Q[30:0],0}`.
  - `cnt` increments each step. On the 32nd step (`cnt==31`), go to DONE.
  - On that same edge, load `m_axis_dout_tdata` with sign-corrected values:
    - `quotient = (sd^sv) ? -Q : Q`
    - `remainder = sd ? -R : R`
    - where `sd` = dividend sign and `sv` = divisor sign.
- **DONE**: `m_axis_dout_tvalid=1`, tdata stable.
  - On `m_axis_dout_tready`: tvalid deasserts, both `have_*` flags clear, state returns to IDLE. tdata keeps its last value.

Arithmetic rules:
- Quotient truncates toward zero; a non-zero remainder takes the dividend's sign.
- Divide by zero is not trapped and produces the natural algorithm result:
  - Unsigned: `q=0xFFFFFFFF`, `r=dividend`.
  - Signed: `q = dividend<0 ? 0x00000001 : 0xFFFFFFFF`, `r=dividend`.
- `0x80000000 / 0xFFFFFFFF` (signed) gives `q=0x80000000`, `r=0` (wraps, no flag).
- Sign bits are ignored when `SIGNED=0`; `0x80000000` is then treated as 2^31.

## Timing

- Reset values, visible the cycle after `rst` is sampled high:
  - state IDLE, `have_*=0`, `cnt=0`
  - `m_axis_dout_tvalid=0`, `m_axis_dout_tdata=0`
  - both `s_axis_*_tready=1`
- `rst` has priority over every event, including mid-CALC and DONE. An in-flight division is discarded with no output.
- Latency: if the second operand is accepted at edge E0, tvalid is first high in the cycle after edge E32, i.e. 32 cycles of CALC. Total throughput is one division per 34 cycles minimum: accept, 32 CALC, DONE handshake.
- tvalid never drops without a handshake, and tdata does not change while tvalid is high.
- In DONE, operand tvalids are ignored (tready=0). No input is accepted in the same cycle as the result handshake; tready rises the cycle after.
- An operand offered while its `have_*` flag is set is not accepted and must be held by the source per AXI-Stream.

## Test plan

- **Unsigned basic:** `SIGNED=0`, dividend=100, divisor=7, both valid in the same cycle, dout_tready=1 -> tvalid high 32 cycles after acceptance for exactly 1 cycle; tdata=`{0x0000000E, 0x00000002}`.
- **Signed signs:** `SIGNED=1`, -7/2 -> `{0xFFFFFFFD, 0xFFFFFFFF}`; 7/-2 -> `{0xFFFFFFFD, 0x00000001}`; -7/-2 -> `{0x00000003, 0xFFFFFFFF}`.
- **Corner values:**
  - `SIGNED=1`, `0x80000000/0xFFFFFFFF` -> `{0x80000000, 0}`.
  - Divide by zero: signed -5/0 -> `{0x00000001, 0xFFFFFFFB}`; unsigned 9/0 -> `{0xFFFFFFFF, 9}`.
  - `SIGNED=0`, `0xFFFFFFFF/1` -> `{0xFFFFFFFF, 0}`.
- **Split arrival and backpressure:**
  - Dividend at cycle 0, divisor at cycle 5 -> dividend tready low from cycle 1; latency counted from cycle 5.
  - Hold dout_tready=0 for 10 cycles in DONE -> tvalid and tdata stable throughout, both treadys low; tready returns 1 the cycle after the handshake.
- **Reset mid-operation:** assert rst at CALC step 15 -> next cycle tvalid=0, tdata=0, treadys=1. A new 20/3 then completes with `{6, 2}` and no stale result appears.
- **Random regression:** 10k random operand pairs, random valid/ready gaps, both `SIGNED` values -> every result matches a `$signed`/unsigned `/` and `%` reference model; exactly one output per operand pair.
